param_burst_sram: RTL and testbench

Parametrised single-port burst SRAM with a start/ready command handshake. It supports incrementing (INCR) and wrapping (WRAP) address sequences, configurable data, address and length widths, and command validation with an error pulse. It sits behind a simple burst master and replaces the fixed 8-bit, 16-entry burst SRAM with incrementing-only bursts.

---
 rtl/param_burst_sram.sv | 117 +++++++++++
 tb/tb_param_burst_sram.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/param_burst_sram.sv
// Single-port burst SRAM with a start/ready command handshake.
// Supports INCR and power-of-two WRAP address sequences; illegal commands pulse err.
module param_burst_sram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              beat_last,
    output logic              ready,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    typedef struct packed {
        logic              mode;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    state_t            state, state_nxt;
    cmd_t              cmd_q;
    logic [LEN_W-1:0]  k_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // command validation on the live inputs
    logic cmd_ok, accept, reject;
    logic len_pow2, len_fits;

    always_comb begin
        len_pow2 = (burst_len & (burst_len - 1'b1)) == '0;
        len_fits = 32'(burst_len) <= 32'(DEPTH);
        cmd_ok   = (burst_len != '0) && (!mode || (len_pow2 && len_fits));
        accept   = ready && start && cmd_ok;
        reject   = ready && start && !cmd_ok;
    end

    // beat address; WRAP mask fits in ADDR_W because len <= DEPTH was enforced
    logic [LEN_W-1:0]  len_m1;
    logic [ADDR_W-1:0] wrap_mask, addr_sum, beat_addr;
    logic              last_beat;

    always_comb begin
        len_m1    = cmd_q.len - 1'b1;
        wrap_mask = ADDR_W'(len_m1);
        addr_sum  = cmd_q.addr + ADDR_W'(k_q);
        beat_addr = cmd_q.mode ? ((cmd_q.addr & ~wrap_mask) | (addr_sum & wrap_mask))
                               : addr_sum;
        last_beat = (k_q == len_m1);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = we ? WR : RD;
            WR, RD:  if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    logic wr_beat, rd_beat, beat;

    always_comb begin
        ready   = (state == IDLE);
        wr_beat = (state == WR);
        rd_beat = (state == RD);
        beat    = wr_beat || rd_beat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            k_q       <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
            beat_last <= 1'b0;
            err       <= 1'b0;
        end else begin
            err       <= reject;
            rd_valid  <= rd_beat;
            beat_last <= beat && last_beat;
            if (accept) begin
                cmd_q <= '{mode: mode, addr: addr, len: burst_len};
                k_q   <= '0;
            end else if (beat) begin
                k_q <= k_q + 1'b1;
            end
            if (rd_beat) data_out <= mem[beat_addr];
        end
    end

    // storage is not reset; a reset edge suppresses the pending write beat
    always_ff @(posedge clk) begin
        if (!rst && wr_beat) mem[beat_addr] <= data_in;
    end

endmodule

// File: tb/tb_param_burst_sram.sv
// Directed bench for param_burst_sram: INCR/WRAP bursts, invalid commands,
// ignored start, mid-burst reset and single-beat bursts.
module tb_param_burst_sram;

    logic       clk = 1'b0;
    logic       rst, start, we, mode;
    logic [3:0] addr;
    logic [4:0] burst_len;
    logic [7:0] data_in, data_out;
    logic       rd_valid, beat_last, ready, err;

    param_burst_sram #(.DATA_W(8), .ADDR_W(4), .LEN_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .we(we), .mode(mode),
        .addr(addr), .burst_len(burst_len), .data_in(data_in),
        .data_out(data_out), .rd_valid(rd_valid), .beat_last(beat_last),
        .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] wbuf [16];
    logic [7:0] rbuf [16];
    int         nrd, nlow, nlast;
    logic       last_final;

    // Issue one command and step through its beats, recording observations.
    // Entered just after a posedge; leaves just after T(len).
    task automatic run_burst(input logic w, input logic m, input logic [3:0] a,
                             input logic [4:0] len);
        nrd = 0; nlow = 0; nlast = 0; last_final = 1'b0;
        for (int i = 0; i < 16; i++) rbuf[i] = 'x;
        we = w; mode = m; addr = a; burst_len = len; start = 1'b1; data_in = wbuf[0];
        @(posedge clk); #1;
        start = 1'b0;
        if (!ready) nlow++;
        for (int k = 0; k < int'(len); k++) begin
            @(posedge clk); #1;
            if (!ready) nlow++;
            if (rd_valid) begin
                if (nrd < 16) rbuf[nrd] = data_out;
                nrd++;
            end
            if (beat_last) begin
                nlast++;
                if (k == int'(len) - 1) last_final = w ? 1'b1 : rd_valid;
            end
            if (k + 1 < 16) data_in = wbuf[k+1];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; we = 1'b0; mode = 1'b0;
        addr = '0; burst_len = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin $display("FAIL rst_ready got %b exp 1", ready); n_bad++; end
        n_cmp++; if (data_out !== 8'h00) begin $display("FAIL rst_data_out got %h exp 00", data_out); n_bad++; end
        n_cmp++; if ({rd_valid, beat_last, err} !== 3'b000)
            begin $display("FAIL rst_flags got %b exp 000", {rd_valid, beat_last, err}); n_bad++; end
    endtask

    task automatic test_incr();
        logic [7:0] e [4];
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
        run_burst(1'b1, 1'b0, 4'd2, 5'd4);
        n_cmp++; if (nlow !== 4) begin $display("FAIL incr_wr_ready_low got %0d exp 4", nlow); n_bad++; end
        n_cmp++; if ({nrd, nlast, last_final} !== {32'd0, 32'd1, 1'b1})
            begin $display("FAIL incr_wr_flags got rd=%0d last=%0d fin=%b exp 0/1/1", nrd, nlast, last_final); n_bad++; end
        run_burst(1'b0, 1'b0, 4'd2, 5'd4);
        e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        n_cmp++; if (nrd !== 4) begin $display("FAIL incr_rd_count got %0d exp 4", nrd); n_bad++; end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rbuf[i] !== e[i]) begin $display("FAIL incr_rd[%0d] got %h exp %h", i, rbuf[i], e[i]); n_bad++; end
        end
        n_cmp++; if ({nlow, nlast, last_final} !== {32'd4, 32'd1, 1'b1})
            begin $display("FAIL incr_rd_timing got low=%0d last=%0d fin=%b exp 4/1/1", nlow, nlast, last_final); n_bad++; end
    endtask

    task automatic test_incr_wrap_around();
        logic [7:0] e [4];
        wbuf[0] = 8'hB0; wbuf[1] = 8'hB1; wbuf[2] = 8'hB2; wbuf[3] = 8'hB3;
        run_burst(1'b1, 1'b0, 4'd14, 5'd4);
        run_burst(1'b0, 1'b0, 4'd14, 5'd4);
        e = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rbuf[i] !== e[i]) begin $display("FAIL rollover_rd14[%0d] got %h exp %h", i, rbuf[i], e[i]); n_bad++; end
        end
        run_burst(1'b0, 1'b0, 4'd0, 5'd2);
        n_cmp++; if ({nrd, rbuf[0], rbuf[1]} !== {32'd2, 8'hB2, 8'hB3})
            begin $display("FAIL rollover_rd0 got n=%0d %h %h exp 2 B2 B3", nrd, rbuf[0], rbuf[1]); n_bad++; end
    endtask

    task automatic test_wrap();
        logic [7:0] e [4];
        wbuf[0] = 8'hC0; wbuf[1] = 8'hC1; wbuf[2] = 8'hC2; wbuf[3] = 8'hC3;
        run_burst(1'b1, 1'b1, 4'd6, 5'd4);
        n_cmp++; if (nlow !== 4) begin $display("FAIL wrap_wr_ready_low got %0d exp 4", nlow); n_bad++; end
        run_burst(1'b0, 1'b0, 4'd4, 5'd4);
        e = '{8'hC2, 8'hC3, 8'hC0, 8'hC1};
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rbuf[i] !== e[i]) begin $display("FAIL wrap_rd[%0d] got %h exp %h", i, rbuf[i], e[i]); n_bad++; end
        end
    endtask

    task automatic test_invalid();
        logic       im [2];
        logic [3:0] ia [2];
        logic [4:0] il [2];
        logic [7:0] e [4];
        im = '{1'b0, 1'b1}; ia = '{4'd2, 4'd0}; il = '{5'd0, 5'd3};
        for (int c = 0; c < 2; c++) begin
            we = 1'b1; mode = im[c]; addr = ia[c]; burst_len = il[c];
            data_in = 8'hEE; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_cmp++; if ({err, ready} !== 2'b11)
                begin $display("FAIL inv%0d_pulse got err=%b ready=%b exp 1 1", c, err, ready); n_bad++; end
            @(posedge clk); #1;
            n_cmp++; if ({err, ready} !== 2'b01)
                begin $display("FAIL inv%0d_after got err=%b ready=%b exp 0 1", c, err, ready); n_bad++; end
        end
        run_burst(1'b0, 1'b0, 4'd2, 5'd4);
        e = '{8'hA0, 8'hA1, 8'hC2, 8'hC3};
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rbuf[i] !== e[i]) begin $display("FAIL inv_rd2[%0d] got %h exp %h", i, rbuf[i], e[i]); n_bad++; end
        end
        run_burst(1'b0, 1'b0, 4'd0, 5'd4);
        e = '{8'hB2, 8'hB3, 8'hA0, 8'hA1};
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rbuf[i] !== e[i]) begin $display("FAIL inv_rd0[%0d] got %h exp %h", i, rbuf[i], e[i]); n_bad++; end
        end
    endtask

    task automatic test_start_hold_and_reset();
        logic [7:0] e [4];
        int         bad_busy;
        wbuf[0] = 8'h55; wbuf[1] = 8'h66; wbuf[2] = 8'h77; wbuf[3] = 8'h88;
        run_burst(1'b1, 1'b0, 4'd8, 5'd4);
        for (int i = 0; i < 8; i++) wbuf[i] = 8'hE0 + 8'(i);
        we = 1'b1; mode = 1'b0; addr = 4'd8; burst_len = 5'd8; data_in = wbuf[0]; start = 1'b1;
        @(posedge clk); #1;
        bad_busy = 0;
        for (int k = 0; k < 3; k++) begin
            if (ready !== 1'b0 || err !== 1'b0) bad_busy++;
            @(posedge clk); #1;
            data_in = wbuf[k+1];
        end
        n_cmp++; if (bad_busy !== 0) begin $display("FAIL hold_busy got %0d bad cycles exp 0", bad_busy); n_bad++; end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({ready, rd_valid, beat_last} !== 3'b100)
            begin $display("FAIL midrst_out got %b exp 100", {ready, rd_valid, beat_last}); n_bad++; end
        run_burst(1'b0, 1'b0, 4'd8, 5'd4);
        e = '{8'hE0, 8'hE1, 8'hE2, 8'h88};
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rbuf[i] !== e[i]) begin $display("FAIL midrst_rd[%0d] got %h exp %h", i, rbuf[i], e[i]); n_bad++; end
        end
    endtask

    task automatic test_single_beat();
        wbuf[0] = 8'hD5;
        run_burst(1'b1, 1'b0, 4'd8, 5'd1);
        n_cmp++; if ({nlow, nlast} !== {32'd1, 32'd1})
            begin $display("FAIL single_wr got low=%0d last=%0d exp 1/1", nlow, nlast); n_bad++; end
        run_burst(1'b0, 1'b0, 4'd8, 5'd1);
        n_cmp++; if ({nlow, nrd, rbuf[0], last_final} !== {32'd1, 32'd1, 8'hD5, 1'b1})
            begin $display("FAIL single_rd got low=%0d n=%0d d=%h fin=%b exp 1/1/D5/1",
                           nlow, nrd, rbuf[0], last_final); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_incr_wrap_around();
        test_wrap();
        test_invalid();
        test_start_hold_and_reset();
        test_single_beat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
